// File: rtl/dram_arbiter.sv
// dram_arbiter
//   Shares the single DataRAM port between the CPU MEM stage and a
//   debug/loader port. The CPU has absolute priority on any cycle it
//   touches memory. A debug request is latched and then waits for a
//   CPU-free cycle. If it waits too long, cpu_hold asks the hazard unit
//   to open a memory-free slot.
//
// Parameters
//   ADDR_W        DataRAM word-address width (byte address bits [7:2])
//   DATA_W        DataRAM data width
//   STARVE_LIMIT  blocked debug cycles before cpu_hold asserts (1..15)
//
// Ports
//   clk, reset                  rising-edge clock, async active-high reset
//   cpu_we/cpu_re/cpu_addr/cpu_din   MEM-stage store/load request
//   dbg_req/dbg_we/dbg_addr/dbg_din  debug request (level, held until ack)
//   dbg_ack, dbg_dout           one-cycle completion pulse and read data
//   cpu_hold                    registered stall request to hazard unit
//   ram_addr/ram_din/ram_we     DataRAM port drive
//   ram_dout                    DataRAM synchronous read data. It is also wired
//                               straight to the pipeline outside this block.
module dram_arbiter #(
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_we,
    input  logic              cpu_re,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_din,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_dout,
    output logic              cpu_hold,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t            state;
    logic              hold_we;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_din;
    logic [3:0]        starve_cnt;
    logic [3:0]        starve_nxt;
    logic              cpu_access;

    // Saturating increment of the starvation counter.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    assign cpu_access = cpu_we | cpu_re;
    assign starve_nxt = sat_inc(starve_cnt);

    // RAM port mux. The CPU always wins. The latched debug request
    // only reaches the RAM in a CPU-free ACCESS cycle. Otherwise the
    // address and data follow the CPU with writes disabled.
    always_comb begin
        ram_addr = cpu_addr;
        ram_din  = cpu_din;
        ram_we   = 1'b0;
        if (cpu_access) begin
            ram_we = cpu_we;
        end else if (state == ACCESS) begin
            ram_addr = hold_addr;
            ram_din  = hold_din;
            ram_we   = hold_we;
        end
    end

    // The RAM read is synchronous, so its data lands exactly in the RESP
    // cycle. A register here would miss the ack cycle, so this path is
    // combinational.
    assign dbg_dout = (state == RESP && !hold_we) ? ram_dout : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hold_we    <= 1'b0;
            hold_addr  <= '0;
            hold_din   <= '0;
            starve_cnt <= 4'd0;
            cpu_hold   <= 1'b0;
            dbg_ack    <= 1'b0;
        end else begin
            dbg_ack <= 1'b0;
            case (state)
                IDLE: begin
                    // The request is captured here only. Later changes on
                    // dbg_* are ignored until the FSM returns to IDLE.
                    if (dbg_req) begin
                        hold_we   <= dbg_we;
                        hold_addr <= dbg_addr;
                        hold_din  <= dbg_din;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cpu_access) begin
                        // Compare against the post-increment count. This makes
                        // cpu_hold rise in the cycle right after the count
                        // reaches the limit.
                        starve_cnt <= starve_nxt;
                        cpu_hold   <= (starve_nxt >= LIMIT);
                    end else begin
                        starve_cnt <= 4'd0;
                        cpu_hold   <= 1'b0;
                        dbg_ack    <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Testbench for dram_arbiter. Directed stimulus with literal expectations,
// plus a transaction-level reference model checked every cycle.
module tb_dram_arbiter;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int LIMIT  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_we, cpu_re;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_din;
    logic              dbg_req, dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_din;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_dout;
    logic              cpu_hold;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_we;
    logic [DATA_W-1:0] ram_dout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_din(dbg_din),
        .dbg_ack(dbg_ack), .dbg_dout(dbg_dout), .cpu_hold(cpu_hold),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    // Synchronous-read DataRAM.
    logic [DATA_W-1:0] mem [64];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model. A debug request is a transaction that is waiting,
    // being acknowledged, or absent. shadow[] is the memory contents the
    // model expects.
    bit                m_pending, m_acking, m_hold, m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_din, m_ack_data;
    int                m_blocked;
    logic [DATA_W-1:0] shadow [64];

    always @(negedge clk) begin : model
        bit                acc;
        logic              e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_din;
        if (reset) begin
            m_pending = 0; m_acking = 0; m_hold = 0; m_blocked = 0;
        end
        acc = cpu_we | cpu_re;
        if (acc) begin
            e_we = cpu_we; e_addr = cpu_addr; e_din = cpu_din;
        end else if (m_pending) begin
            e_we = m_we; e_addr = m_addr; e_din = m_din;
        end else begin
            e_we = 1'b0; e_addr = cpu_addr; e_din = cpu_din;
        end
        chk("m_ram_we",   ram_we,   e_we);
        chk("m_ram_addr", ram_addr, e_addr);
        chk("m_ram_din",  ram_din,  e_din);
        chk("m_dbg_ack",  dbg_ack,  m_acking);
        chk("m_dbg_dout", dbg_dout, m_acking ? m_ack_data : '0);
        chk("m_cpu_hold", cpu_hold, m_hold);
        if (!reset) begin
            if (m_acking) begin
                m_acking = 0;
            end else if (m_pending) begin
                if (acc) begin
                    if (m_blocked < 15) m_blocked++;
                    m_hold = (m_blocked >= LIMIT);
                end else begin
                    m_ack_data = m_we ? '0 : shadow[m_addr];
                    m_pending = 0; m_acking = 1; m_blocked = 0; m_hold = 0;
                end
            end else if (dbg_req) begin
                m_pending = 1; m_we = dbg_we; m_addr = dbg_addr; m_din = dbg_din;
            end
        end
        if (e_we) shadow[e_addr] = e_din;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One complete debug transaction. Returns the read data and the number
    // of cycles from request to ack (-1 if no ack within the budget).
    task automatic dbg_op(input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d,
                          output logic [DATA_W-1:0] rd, output int lat);
        cyc();
        dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_din = d;
        rd = '0; lat = -1;
        for (int i = 1; i <= 40; i++) begin
            cyc(); #2;
            if (dbg_ack) begin
                rd = dbg_dout; lat = i; dbg_req = 0;
                break;
            end
        end
        dbg_req = 0;
    endtask

    initial begin
        logic [DATA_W-1:0] rd;
        int                lat;
        for (int i = 0; i < 64; i++) begin
            mem[i] = '0;
            shadow[i] = '0;
        end
        ram_dout = '0;
        reset = 1; cpu_we = 0; cpu_re = 0; cpu_addr = '0; cpu_din = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_din = '0;
        repeat (3) cyc();
        #2;
        chk("rst_ack", dbg_ack, 1'b0);
        chk("rst_hold", cpu_hold, 1'b0);
        chk("rst_dout", dbg_dout, 32'h0);
        chk("rst_ram_we", ram_we, 1'b0);
        cyc(); reset = 0;

        // Idle CPU: write 0xDEADBEEF to addr 5, then read it back.
        cyc(); dbg_req = 1; dbg_we = 1; dbg_addr = 6'd5; dbg_din = 32'hDEADBEEF; #2;
        chk("t1_c0_ram_we", ram_we, 1'b0);
        cyc(); dbg_addr = 6'd9; dbg_din = 32'h11111111; #2;
        chk("t1_c1_ram_we", ram_we, 1'b1);
        chk("t1_c1_ram_addr", ram_addr, 6'd5);
        chk("t1_c1_ram_din", ram_din, 32'hDEADBEEF);
        chk("t1_c1_ack", dbg_ack, 1'b0);
        cyc(); #2;
        chk("t1_c2_ack", dbg_ack, 1'b1);
        chk("t1_c2_dout", dbg_dout, 32'h0);
        dbg_req = 0;
        cyc(); #2;
        chk("t1_c3_ack", dbg_ack, 1'b0);
        dbg_op(1'b0, 6'd5, 32'h0, rd, lat);
        chk("t1_rd_data", rd, 32'hDEADBEEF);
        chk("t1_rd_lat", lat, 2);

        // Contention: CPU stores in cycles 1-2 delay the debug write.
        cyc(); dbg_req = 1; dbg_we = 1; dbg_addr = 6'd10; dbg_din = 32'hA5A5A5A5;
        cyc(); cpu_we = 1; cpu_addr = 6'd3; cpu_din = 32'h12345678; #2;
        chk("t2_c1_ram_we", ram_we, 1'b1);
        chk("t2_c1_ram_addr", ram_addr, 6'd3);
        chk("t2_c1_ram_din", ram_din, 32'h12345678);
        cyc(); cpu_addr = 6'd4; cpu_din = 32'h87654321; #2;
        chk("t2_c2_ram_addr", ram_addr, 6'd4);
        chk("t2_c2_ram_din", ram_din, 32'h87654321);
        cyc(); cpu_we = 0; #2;
        chk("t2_c3_ram_we", ram_we, 1'b1);
        chk("t2_c3_ram_addr", ram_addr, 6'd10);
        chk("t2_c3_ram_din", ram_din, 32'hA5A5A5A5);
        chk("t2_c3_ack", dbg_ack, 1'b0);
        cyc(); #2;
        chk("t2_c4_ack", dbg_ack, 1'b1);
        chk("t2_c4_hold", cpu_hold, 1'b0);
        dbg_req = 0;
        dbg_op(1'b0, 6'd4, 32'h0, rd, lat);
        chk("t2_rd_cpu_data", rd, 32'h87654321);
        chk("t2_rd_lat", lat, 2);

        // Starvation: 6 blocked cycles, cpu_hold from the 5th.
        cyc(); dbg_req = 1; dbg_we = 0; dbg_addr = 6'd10;
        for (int k = 1; k <= 6; k++) begin
            cyc(); cpu_re = 1; cpu_addr = 6'd7; #2;
            chk($sformatf("t3_hold_k%0d", k), cpu_hold, (k >= 5) ? 1'b1 : 1'b0);
            chk($sformatf("t3_ack_k%0d", k), dbg_ack, 1'b0);
        end
        cyc(); cpu_re = 0; #2;
        chk("t3_acc_addr", ram_addr, 6'd10);
        chk("t3_acc_we", ram_we, 1'b0);
        chk("t3_acc_hold", cpu_hold, 1'b1);
        cyc(); #2;
        chk("t3_ack", dbg_ack, 1'b1);
        chk("t3_dout", dbg_dout, 32'hA5A5A5A5);
        chk("t3_hold_clr", cpu_hold, 1'b0);
        dbg_req = 0;

        // Back-to-back: request held through the ack with new addr/data.
        cyc(); dbg_req = 1; dbg_we = 1; dbg_addr = 6'd20; dbg_din = 32'h1;
        cyc(); #2;
        chk("t4_w1_we", ram_we, 1'b1);
        chk("t4_w1_addr", ram_addr, 6'd20);
        dbg_addr = 6'd21; dbg_din = 32'h2;
        cyc(); #2;
        chk("t4_ack1", dbg_ack, 1'b1);
        chk("t4_resp_we", ram_we, 1'b0);
        cyc(); #2;
        chk("t4_idle_ack", dbg_ack, 1'b0);
        chk("t4_idle_we", ram_we, 1'b0);
        cyc(); #2;
        chk("t4_w2_we", ram_we, 1'b1);
        chk("t4_w2_addr", ram_addr, 6'd21);
        chk("t4_w2_din", ram_din, 32'h2);
        chk("t4_w2_ack", dbg_ack, 1'b0);
        cyc(); #2;
        chk("t4_ack2", dbg_ack, 1'b1);
        dbg_req = 0;
        dbg_op(1'b0, 6'd20, 32'h0, rd, lat);
        chk("t4_rd20", rd, 32'h1);
        dbg_op(1'b0, 6'd21, 32'h0, rd, lat);
        chk("t4_rd21", rd, 32'h2);

        // Reset in mid-ACCESS under CPU contention aborts the debug write.
        cyc(); dbg_req = 1; dbg_we = 1; dbg_addr = 6'd30; dbg_din = 32'hCAFE0000;
        for (int k = 1; k <= 6; k++) begin
            cyc(); cpu_we = 1; cpu_addr = 6'd2; cpu_din = 32'h55; #2;
        end
        chk("t5_hold_pre", cpu_hold, 1'b1);
        #1; reset = 1; cpu_we = 0; dbg_req = 0; #1;
        chk("t5_rst_hold", cpu_hold, 1'b0);
        chk("t5_rst_ack", dbg_ack, 1'b0);
        chk("t5_rst_dout", dbg_dout, 32'h0);
        chk("t5_rst_ram_we", ram_we, 1'b0);
        cyc(); cyc();
        cyc(); reset = 0;
        for (int k = 0; k < 5; k++) begin
            cyc(); #2;
            chk($sformatf("t5_post_we_%0d", k), ram_we, 1'b0);
        end
        dbg_op(1'b0, 6'd30, 32'h0, rd, lat);
        chk("t5_rd30", rd, 32'h0);
        chk("t5_rd30_lat", lat, 2);
        dbg_op(1'b0, 6'd2, 32'h0, rd, lat);
        chk("t5_rd2", rd, 32'h55);

        repeat (2) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6, the DataRAM word-address width (byte address bits [7:2]).
REQ-002 Parameter DATA_W, default 32, the DataRAM data width.
REQ-003 Parameter STARVE_LIMIT, default 4, the number of blocked debug cycles before cpu_hold asserts; legal range 1..15.
REQ-004 One clock and one asynchronous active-high reset; clk and reset are named as the rest of the CPU names them.
REQ-005 clk  input  1  rising-edge clock shared with the pipeline and DataRAM.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 cpu_we  input  1  MEM-stage store request (MemWrite_mem).
REQ-008 cpu_re  input  1  MEM-stage load request (MemRead_mem).
REQ-009 cpu_addr  input  ADDR_W  MEM-stage word address (ALUResult_mem[7:2]).
REQ-010 cpu_din  input  DATA_W  MEM-stage store data.
REQ-011 dbg_req  input  1  debug/loader access request, level, held until dbg_ack.
REQ-012 dbg_we  input  1  debug write (1) or read (0), sampled with dbg_req.
REQ-013 dbg_addr  input  ADDR_W  debug word address.
REQ-014 dbg_din  input  DATA_W  debug write data.
REQ-015 dbg_ack  output  1  one-cycle completion pulse.
REQ-016 dbg_dout  output  DATA_W  debug read data, valid while dbg_ack=1.
REQ-017 cpu_hold  output  1  registered request to the hazard unit to open a memory-free slot.
REQ-018 ram_addr, ram_din, ram_we  output  ADDR_W/DATA_W/1  DataRAM port drive.
REQ-019 ram_dout  input  DATA_W  DataRAM synchronous read data, valid the cycle after the address.

Function
REQ-020 cpu_access = cpu_we | cpu_re; the CPU SHALL always win any cycle in which cpu_access=1.
REQ-021 When cpu_access=1, ram_addr/ram_din/ram_we SHALL equal cpu_addr/cpu_din/cpu_we combinationally.
REQ-022 FSM states SHALL be IDLE, ACCESS and RESP.
REQ-023 IDLE: if dbg_req=1, latch dbg_we/dbg_addr/dbg_din into holding registers and go to ACCESS; otherwise stay in IDLE.
REQ-024 ACCESS with cpu_access=0: drive the RAM from the holding registers (ram_we = latched we) and go to RESP.
REQ-025 ACCESS with cpu_access=1: stay in ACCESS and increment the starvation counter, saturating at 15.
REQ-026 RESP: dbg_ack=1 for exactly one cycle; dbg_dout = ram_dout for reads and 0 for writes; then go to IDLE.
REQ-027 Best-case latency SHALL be dbg_req seen at cycle 0, RAM access at cycle 1, dbg_ack at cycle 2.
REQ-028 When the FSM is not driving a debug access and cpu_access=0, ram_we SHALL be 0 and ram_addr/ram_din SHALL follow the CPU inputs.
REQ-029 cpu_hold SHALL be registered and SHALL be 1 in the cycle after the counter reaches STARVE_LIMIT.
REQ-030 cpu_hold SHALL clear in the cycle the debug access is performed (ACCESS to RESP), and the counter SHALL clear at the same time.
REQ-031 Changes to dbg_* inputs after latching SHALL be ignored until the next IDLE.
REQ-032 dbg_req still high in the IDLE cycle after an ack SHALL start a new transaction.
REQ-033 ram_dout SHALL also pass unmodified to the pipeline (MemDout_wb); the arbiter SHALL NOT gate the CPU read path.

Reset
REQ-034 reset SHALL force, asynchronously: state IDLE, counter 0, holding registers 0, cpu_hold 0, dbg_ack 0, dbg_dout 0.
REQ-035 reset during ACCESS or RESP SHALL abort the transaction with no ack, and SHALL NOT produce a debug RAM write after reset deasserts.

Verification
REQ-036 Idle CPU: dbg_req, write, addr 5, din 0xDEADBEEF at cycle 0 -> ram_we=1 with addr 5 at cycle 1, dbg_ack at cycle 2; a debug read of addr 5 -> dbg_dout 0xDEADBEEF with ack.
REQ-037 Contention: cpu_we=1 for cycles 1-2 while debug is pending -> RAM carries CPU values in cycles 1-2, debug access at cycle 3, ack at cycle 4.
REQ-038 Starvation: cpu_re held for 6 cycles with STARVE_LIMIT=4 -> cpu_hold=1 from the 5th blocked cycle; drop cpu_re -> debug access that cycle, cpu_hold=0 the next cycle.
REQ-039 Back-to-back: dbg_req held through the ack with new addr/data -> second ack 3 cycles after the first, with no lost or duplicated write.
REQ-040 Reset mid-ACCESS under CPU contention -> outputs 0 immediately; after release, no ram_we is issued from the debug side.
